sw_duty_ramp: RTL and testbench
===============================

Name: sw_duty_ramp

Overview:
- Upstream conditioning stage for the PWM LED driver.
- Takes raw board switches, synchronizes and debounces them, then slews the 4-bit duty code that feeds the PWM `sw` input, one LSB at a time.
- Purpose: brightness fades smoothly instead of jumping, and switch bounce never reaches the PWM comparator.

Parameters:
- W, 4, width of switch vector and duty code.
- DB_CYCLES, 50000, consecutive stable synchronized cycles required to accept a new switch value (>=2).
- STEP_CYCLES, 500000, clk cycles between successive duty steps while ramping (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sw_raw  input  W  raw asynchronous switch inputs.
- duty_sw  output  W  registered duty code to the PWM stage.
- target  output  W  debounced, accepted switch value.
- busy  output  1  high while duty_sw != target.

Behaviour:
- Reset (async assert, sync release): sync flops, candidate, debounce counter, target, duty_sw, step prescaler all 0; busy=0; state IDLE.
- Sync: 2-flop synchronizer per bit; sw_s = second-stage output. Latency from sw_raw to sw_s is 2 clk.
- Debounce:
  - candidate register tracks sw_s.
  - When sw_s != candidate: candidate <= sw_s, db_cnt <= 0.
  - Otherwise db_cnt increments and saturates at DB_CYCLES-1.
  - When db_cnt == DB_CYCLES-1 and candidate != target, target <= candidate.
  - Net: target updates after sw_s has held one value for DB_CYCLES+1 consecutive edges.
  - A change shorter than that never reaches target.
  - db_cnt width = clog2(DB_CYCLES).
- FSM states IDLE, UP, DOWN:
  - IDLE: if target > duty_sw -> UP; if target < duty_sw -> DOWN. Prescaler cleared on the transition.
  - UP/DOWN: prescaler counts 0..STEP_CYCLES-1 and wraps. On the cycle prescaler == STEP_CYCLES-1 the step decision is made:
    - if target > duty_sw, duty_sw += 1 (state UP);
    - if target < duty_sw, duty_sw -= 1 (state DOWN);
    - if the resulting duty_sw == target, go to IDLE.
  - Direction is re-evaluated at every step, so a target change mid-ramp reverses or extends the ramp with no extra wait.
  - If target changes to equal duty_sw between steps, go to IDLE on the next clk without stepping.
- busy is combinational (duty_sw != target), i.e. registered-derived and glitch-free.
- Arithmetic: duty_sw never wraps. Steps are only taken toward target, so 0 and 2^W-1 are natural bounds.
- First step occurs STEP_CYCLES clk after leaving IDLE. A full 0->15 ramp takes 15*STEP_CYCLES clk.
- Reset mid-ramp: duty_sw returns to 0 immediately. No ramp-down.

Optional Feature:
- Macro SW_DUTY_RAMP_EN.
- Defined: slew FSM as above.
- Undefined:
  - FSM and prescaler are removed; duty_sw <= target one clk after target updates.
  - busy is high only during that single cycle (duty_sw != target).
  - STEP_CYCLES is unused.

Test Plan (DB_CYCLES=4, STEP_CYCLES=3, macro defined unless stated):
- Reset: assert rst asynchronously mid-cycle with duty_sw=7 -> duty_sw, target, busy go 0 immediately; hold rst with sw_raw=4'hF -> all stay 0.
- Bounce rejection: sw_raw toggles 0<->F every 2 clk for 40 clk, then settles at 0 -> target stays 0, busy never asserts.
- Debounce accept: sw_raw 0->4'h5 held -> target=5 exactly 7 edges after the sw_raw change (2 sync + 5 debounce); busy rises the same cycle.
- Ramp up: from target=5 -> duty_sw steps 1,2,3,4,5, each 3 clk apart; busy falls the cycle duty_sw becomes 5; FSM returns to IDLE.
- Mid-ramp reversal: ramping 0->12 with duty_sw=6, change sw to 2 -> after debounce, next step gives 5, continues down to 2; no step skipped or repeated.
- Macro undefined: sw_raw 0->4'hA -> duty_sw=A one clk after target=A; busy high for exactly one cycle.

Source files
------------

// File: rtl/sw_duty_ramp.sv
// -----------------------------------------------------------------------------
// sw_duty_ramp
//   Conditioning stage ahead of the PWM LED driver. Raw board switches are
//   passed through a two-flop synchronizer and debounced. The accepted value,
//   `target`, then drives the 4-bit duty code `duty_sw`. With slewing enabled,
//   `duty_sw` moves one LSB at a time toward `target`, so brightness fades
//   instead of jumping. Switch bounce never reaches the PWM comparator.
//
//   Build option:
//     SW_DUTY_RAMP_EN defined   : slew FSM (IDLE/UP/DOWN) with a step prescaler.
//     SW_DUTY_RAMP_EN undefined : duty_sw follows target one clk later, and
//                                 STEP_CYCLES is unused.
//
//   Ports:
//     clk      system clock
//     rst      asynchronous assert, active-high reset
//     sw_raw   raw asynchronous switch inputs [W-1:0]
//     duty_sw  registered duty code to the PWM stage [W-1:0]
//     target   debounced, accepted switch value [W-1:0]
//     busy     high while duty_sw != target
// -----------------------------------------------------------------------------
module sw_duty_ramp #(
  parameter int W           = 4,
  parameter int DB_CYCLES   = 50000,
  parameter int STEP_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw_raw,
  output logic [W-1:0] duty_sw,
  output logic [W-1:0] target,
  output logic         busy
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [W-1:0]   sync1_reg;
  logic [W-1:0]   sync2_reg;
  logic [W-1:0]   cand_reg;
  logic [W-1:0]   target_reg;
  logic [W-1:0]   duty_reg;
  logic [DBW-1:0] db_cnt_reg;

  // Two-flop synchronizer. sync2_reg is the synchronized switch value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce. Any change in the synchronized value restarts the count.
  // target is only accepted once the count has saturated and the value is
  // still the same on the accepting edge. This means sw_s must hold for
  // DB_CYCLES+1 consecutive edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_reg   <= '0;
      db_cnt_reg <= '0;
      target_reg <= '0;
    end else if (sync2_reg != cand_reg) begin
      cand_reg   <= sync2_reg;
      db_cnt_reg <= '0;
    end else if (db_cnt_reg != DB_LAST) begin
      db_cnt_reg <= db_cnt_reg + 1'b1;
    end else if (cand_reg != target_reg) begin
      target_reg <= cand_reg;
    end
  end

`ifdef SW_DUTY_RAMP_EN
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] STEP_LAST = PW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;
  logic [W-1:0]  duty_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      duty_reg  <= '0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      duty_reg  <= duty_next;
    end
  end

  // Direction is chosen again at every step. Because of this, a target that
  // moves during a ramp will reverse or extend the ramp without restarting
  // the prescaler. Steps only go toward target, so duty_sw cannot wrap.
  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    duty_next  = duty_reg;
    case (state_reg)
      IDLE: begin
        presc_next = '0;
        if (target_reg > duty_reg)
          state_next = UP;
        else if (target_reg < duty_reg)
          state_next = DOWN;
      end
      UP, DOWN: begin
        if (target_reg == duty_reg) begin
          // target moved onto duty_sw between steps, so stop without stepping.
          state_next = IDLE;
          presc_next = '0;
        end else if (presc_reg == STEP_LAST) begin
          presc_next = '0;
          if (target_reg > duty_reg) begin
            duty_next  = duty_reg + 1'b1;
            state_next = UP;
          end else begin
            duty_next  = duty_reg - 1'b1;
            state_next = DOWN;
          end
          if (duty_next == target_reg)
            state_next = IDLE;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        presc_next = '0;
      end
    endcase
  end
`else
  // The step rate has no meaning without the slew FSM.
  localparam int step_cycles_unused = STEP_CYCLES;

  // No slewing: duty_sw follows target one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      duty_reg <= '0;
    else
      duty_reg <= target_reg;
  end
`endif

  assign duty_sw = duty_reg;
  assign target  = target_reg;
  assign busy    = (duty_reg != target_reg);

endmodule

// File: tb/tb_sw_duty_ramp.sv
// -----------------------------------------------------------------------------
// tb_sw_duty_ramp
//   Directed testbench for sw_duty_ramp with DB_CYCLES=4 and STEP_CYCLES=3.
//   Expected values are worked out by hand from the debounce and step timing.
//   The sections follow the build option (SW_DUTY_RAMP_EN) that the DUT was
//   built with.
// -----------------------------------------------------------------------------
module tb_sw_duty_ramp;

  logic       clk;
  logic       rst;
  logic [3:0] sw_raw;
  logic [3:0] duty_sw;
  logic [3:0] target;
  logic       busy;

  int checks;
  int failures;

  sw_duty_ramp #(
    .W          (4),
    .DB_CYCLES  (4),
    .STEP_CYCLES(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .duty_sw(duty_sw),
    .target (target),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge before sampling.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic busy_seen;
  logic target_seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sw_raw   = 4'h0;

    // Check the reset state.
    tick(3);
    check("rst_duty", 32'(duty_sw), 32'h0);
    check("rst_target", 32'(target), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(2);

    // Bounce rejection: toggle every 2 clk for 40 clk, then settle at 0.
    busy_seen   = 1'b0;
    target_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw_raw = (i % 2 == 1) ? 4'hF : 4'h0;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        busy_seen   = busy_seen | busy;
        target_seen = target_seen | (target != 4'h0);
      end
    end
    sw_raw = 4'h0;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      busy_seen   = busy_seen | busy;
      target_seen = target_seen | (target != 4'h0);
    end
    check("bounce_target_moved", 32'(target_seen), 32'h0);
    check("bounce_busy_seen", 32'(busy_seen), 32'h0);

    // Debounce accept: 2 sync edges plus 5 debounce edges gives 7 edges.
    sw_raw = 4'h5;
    tick(6);
    check("db_edge6_target", 32'(target), 32'h0);
    tick(1);
    check("db_edge7_target", 32'(target), 32'h5);
    check("db_edge7_busy", 32'(busy), 32'h1);
    check("db_edge7_duty", 32'(duty_sw), 32'h0);

`ifdef SW_DUTY_RAMP_EN
    // Ramp up. The FSM leaves IDLE 1 edge after target moves, and the first
    // step comes 3 edges after that. Later steps are 3 edges apart.
    tick(3);
    check("up_pre1", 32'(duty_sw), 32'h0);
    tick(1);
    check("up_step1", 32'(duty_sw), 32'h1);
    for (int k = 2; k <= 5; k++) begin
      tick(2);
      check($sformatf("up_pre%0d", k), 32'(duty_sw), 32'(k - 1));
      tick(1);
      check($sformatf("up_step%0d", k), 32'(duty_sw), 32'(k));
    end
    check("up_done_busy", 32'(busy), 32'h0);
    tick(6);
    check("up_idle_hold", 32'(duty_sw), 32'h5);

    // Mid-ramp reversal. With sw=C set at E0, target=C at E0+7 and duty
    // reaches 6 at E0+11. With sw=2 set at E0+5, target=2 at E0+12 while
    // duty is still 6. The next step at E0+14 gives 5, and the ramp then
    // continues down to 2.
    sw_raw = 4'hC;
    tick(5);
    check("rev_e5_duty", 32'(duty_sw), 32'h5);
    check("rev_e5_target", 32'(target), 32'h5);
    sw_raw = 4'h2;
    tick(6);
    check("rev_e11_duty", 32'(duty_sw), 32'h6);
    check("rev_e11_target", 32'(target), 32'hC);
    tick(1);
    check("rev_e12_target", 32'(target), 32'h2);
    check("rev_e12_duty", 32'(duty_sw), 32'h6);
    tick(1);
    check("rev_e13_duty", 32'(duty_sw), 32'h6);
    tick(1);
    check("rev_e14_duty", 32'(duty_sw), 32'h5);
    tick(3);
    check("rev_e17_duty", 32'(duty_sw), 32'h4);
    tick(3);
    check("rev_e20_duty", 32'(duty_sw), 32'h3);
    tick(3);
    check("rev_e23_duty", 32'(duty_sw), 32'h2);
    check("rev_e23_busy", 32'(busy), 32'h0);
    tick(4);
    check("rev_idle_hold", 32'(duty_sw), 32'h2);
`else
    // No slewing: duty follows target one clk later, and busy lasts one cycle.
    tick(1);
    check("follow_duty", 32'(duty_sw), 32'h5);
    check("follow_busy", 32'(busy), 32'h0);
    tick(3);
    check("follow_hold", 32'(duty_sw), 32'h5);

    sw_raw = 4'hA;
    tick(6);
    check("a_edge6_target", 32'(target), 32'h5);
    tick(1);
    check("a_edge7_target", 32'(target), 32'hA);
    check("a_edge7_duty", 32'(duty_sw), 32'h5);
    check("a_edge7_busy", 32'(busy), 32'h1);
    tick(1);
    check("a_edge8_duty", 32'(duty_sw), 32'hA);
    check("a_edge8_busy", 32'(busy), 32'h0);
`endif

    // Bring duty to 7, then assert reset asynchronously in mid-cycle.
    sw_raw = 4'h7;
    for (int n = 0; n < 100 && duty_sw != 4'h7; n++)
      tick(1);
    check("reach7_duty", 32'(duty_sw), 32'h7);
    #3;
    rst = 1'b1;
    #1;
    check("arst_duty", 32'(duty_sw), 32'h0);
    check("arst_target", 32'(target), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    sw_raw = 4'hF;
    tick(12);
    check("rst_hold_duty", 32'(duty_sw), 32'h0);
    check("rst_hold_target", 32'(target), 32'h0);
    check("rst_hold_busy", 32'(busy), 32'h0);
    sw_raw = 4'h0;
    rst    = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
